// File: rtl/cs_sample_feeder.sv
// Sample FIFO that pre-fills one CS window, then streams one sample per clock onto X.
// Also drives the CS reset pulse, the window-full flag and a sticky underrun flag.
module cs_sample_feeder #(
  parameter  int DEPTH  = 16,
  parameter  int WIN    = 9,
  parameter  int DATA_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1,
  localparam int CW     = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] X,
  output logic              cs_reset,
  output logic              y_valid,
  output logic              underrun,
  input  logic              clr_err,
  output logic [LW-1:0]     level
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] WIN_L   = LW'(WIN);
  localparam logic [CW-1:0] WIN_C   = CW'(WIN);

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic                cs_reset_q, cs_reset_d;
  logic [CW-1:0]       win_cnt_q, win_cnt_d;
  logic                underrun_q, underrun_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic full, empty, push, pop, ur_evt, win_ready;

  assign full      = (count_q == DEPTH_L);
  assign empty     = (count_q == '0);
  assign win_ready = (count_q >= WIN_L);
  assign push      = in_valid && !full;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (en) state_d = FILL;
      FILL: begin
        if (!en)            state_d = IDLE;
        else if (win_ready) state_d = STREAM;
      end
      STREAM: if (!en || empty) state_d = FLUSH;
      FLUSH:  state_d = en ? FILL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode: the pop on the FILL->STREAM edge loads the first sample
  always_comb begin
    pop        = 1'b0;
    ur_evt     = 1'b0;
    y_valid    = 1'b0;
    cs_reset_d = 1'b1;
    unique case (state_q)
      FILL:    pop = en && win_ready;
      STREAM: begin
        pop     = en && !empty;
        ur_evt  = en && empty;
        y_valid = (win_cnt_q == WIN_C);
      end
      default: ;
    endcase
    cs_reset_d = (state_d != STREAM);
  end

  // FIFO bookkeeping, X register, window counter, error flag
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    x_d = pop ? mem_q[rd_ptr_q] : '0;
    if (state_q != STREAM)     win_cnt_d = '0;
    else if (win_cnt_q == WIN_C) win_cnt_d = win_cnt_q;
    else                       win_cnt_d = win_cnt_q + CW'(1);
    if (ur_evt)       underrun_d = 1'b1;
    else if (clr_err) underrun_d = 1'b0;
    else              underrun_d = underrun_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      x_q        <= '0;
      cs_reset_q <= 1'b1;
      win_cnt_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      x_q        <= x_d;
      cs_reset_q <= cs_reset_d;
      win_cnt_q  <= win_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready = !full;
  assign X        = x_q;
  assign cs_reset = cs_reset_q;
  assign underrun = underrun_q;
  assign level    = count_q;

endmodule

// File: tb/tb_cs_sample_feeder.sv
// Scoreboard bench for cs_sample_feeder: pushed samples queue their expected X values,
// a negedge monitor consumes them whenever the feeder is streaming.
module tb_cs_sample_feeder;
  localparam int DEPTH = 16;
  localparam int WIN   = 9;

  logic       clk = 1'b0;
  logic       reset, en, in_valid, clr_err;
  logic [7:0] in_data;
  logic       in_ready, cs_reset, y_valid, underrun;
  logic [7:0] X;
  logic [4:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  int seen = 0;

  cs_sample_feeder #(.DEPTH(DEPTH), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .X(X), .cs_reset(cs_reset), .y_valid(y_valid),
    .underrun(underrun), .clr_err(clr_err), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; en = 1'b0; in_valid = 1'b0; clr_err = 1'b0; in_data = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic push_vals(input int first, input int step, input int n, input bit track);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(first + i * step);
      if (track) exp_q.push_back(8'(first + i * step));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_underrun(input string name);
    for (int i = 0; i < 40 && !underrun; i++) tick();
    check(name, 32'(underrun), 1);
  endtask

  // Monitor: X/y_valid checked against the scoreboard while CS is out of reset
  always @(negedge clk) begin
    if (reset) begin
      if (!cs_reset) begin
        if (exp_q.size() == 0) begin
          check("x_unexpected", 32'(X), 32'hFFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("x_stream", 32'(X), 32'(e));
        end
        check("y_valid_stream", 32'(y_valid), 32'(seen >= WIN));
        seen++;
      end else begin
        seen = 0;
        check("x_idle", 32'(X), 0);
        check("y_valid_idle", 32'(y_valid), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and idle fill
    do_reset();
    check("rst_x", 32'(X), 0);
    check("rst_cs_reset", 32'(cs_reset), 1);
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_level", 32'(level), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    push_vals(1, 1, 9, 1'b0);
    tick();
    check("t1_level", 32'(level), 9);
    check("t1_x", 32'(X), 0);
    check("t1_cs_reset", 32'(cs_reset), 1);
    check("t1_in_ready", 32'(in_ready), 1);

    // Prefill 10..90, start, then sustain one push per cycle
    do_reset();
    push_vals(10, 10, 9, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(100 + i);
      exp_q.push_back(8'(100 + i));
      tick();
      @(negedge clk);
      check("t3_level_const", 32'(level), 10);
      check("t3_no_underrun", 32'(underrun), 0);
    end
    in_valid = 1'b0;
    wait_underrun("t3_drain_underrun");
    check("t3_drained", 32'(exp_q.size()), 0);

    // 12 samples then underrun, FLUSH, FILL, clear
    do_reset();
    push_vals(1, 1, 12, 1'b1);
    en = 1'b1;
    wait_underrun("t4_underrun");
    check("t4_flush_cs_reset", 32'(cs_reset), 1);
    check("t4_flush_y_valid", 32'(y_valid), 0);
    check("t4_flush_x", 32'(X), 0);
    tick();
    check("t4_fill_cs_reset", 32'(cs_reset), 1);
    check("t4_fill_level", 32'(level), 0);
    check("t4_sticky", 32'(underrun), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t4_clr_err", 32'(underrun), 0);
    check("t4_drained", 32'(exp_q.size()), 0);
    en = 1'b0;
    tick();

    // Full FIFO across pointer wrap (pointers start at 12)
    push_vals(200, 1, 16, 1'b1);
    check("t5_full_level", 32'(level), 16);
    check("t5_full_in_ready", 32'(in_ready), 0);
    push_vals(8'hEE, 0, 1, 1'b0);
    check("t5_reject_level", 32'(level), 16);
    en = 1'b1;
    tick();
    @(negedge clk);
    check("t5_fill_in_ready", 32'(in_ready), 0);
    tick();
    @(negedge clk);
    check("t5_pop_in_ready", 32'(in_ready), 1);
    check("t5_pop_level", 32'(level), 15);
    wait_underrun("t5_underrun");
    check("t5_drained", 32'(exp_q.size()), 0);
    en = 1'b0;
    repeat (2) tick();

    // Async reset in the middle of a stream
    push_vals(50, 1, 10, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 20 && cs_reset; i++) tick();
    check("t6_streaming", 32'(cs_reset), 0);
    repeat (3) tick();
    check("t6_pre_underrun", 32'(underrun), 1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_x", 32'(X), 0);
    check("t6_cs_reset", 32'(cs_reset), 1);
    check("t6_y_valid", 32'(y_valid), 0);
    check("t6_level", 32'(level), 0);
    check("t6_underrun", 32'(underrun), 0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
